seq_frame_tx: RTL
=================

# seq_frame_tx

Serial frame transmitter that drives the one-bit line consumed by the team's "1011" sequence detector FSM. It accepts a parallel word through a valid/ready handshake and shifts out one bit per clock: the 4-bit preamble 1011, the data word MSB first, an optional parity bit, and an idle gap of zeros. The block is the transmit end of the serial link. Its output feeds the detector's `data_in` directly.

## Interface
Parameters:
- `DATA_W`, default 8: payload width in bits. Legal values are ≥ 1.
- `GAP_BITS`, default 2: number of forced zero bits after each frame. Legal values are ≥ 1.

Ports:
- `clk`, input, 1 bit: single clock. All logic is on the rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `in_valid`, input, 1 bit: `in_data` holds a word to send.
- `in_data`, input, `DATA_W` bits: payload.
- `in_ready`, output, 1 bit: block can accept a word. Equals `(state == IDLE) && !reset`.
- `data_out`, output, 1 bit: serial line. Registered.
- `busy`, output, 1 bit: high when `state != IDLE`.
- `frame_done`, output, 1 bit: one-cycle pulse on the last gap bit.
- `state`, output, 3 bits: current state encoding, exposed for debug.

## Operation
- States and encodings: IDLE=3'd0, PRE=3'd1, DATA=3'd2, PAR=3'd3, GAP=3'd4. Codes 5–7 are unreachable. If entered, the block goes to IDLE on the next edge.
- Accept: `in_valid && in_ready` at a rising edge loads `in_data` into the internal shift register and moves the FSM to PRE. While not in IDLE, `in_data` and `in_valid` are ignored. A word is never half-captured.
- PRE: drives 1, 0, 1, 1 over 4 cycles using a 2-bit index.
- DATA: drives shift-register bit `[DATA_W-1]` and shifts left each cycle, for `DATA_W` cycles. The bit counter is `$clog2(DATA_W+1)` bits wide, counts down, and the FSM exits when the counter reaches 1.
- PAR: present only when the parity feature is compiled in. See Configuration.
- GAP: drives 0 for `GAP_BITS` cycles. `frame_done` is asserted in the last GAP cycle. The FSM then returns to IDLE.
- IDLE: `data_out` is 0.
- No bit stuffing is performed. A payload containing 1011 also triggers a downstream detector; this behaviour is accepted.
- Reset values, at the first edge with `reset` high:
  - `state` = IDLE, `data_out` = 0, `busy` = 0, `frame_done` = 0.
  - Counters and shift register are cleared.
  - `in_ready` = 0 while `reset` is high.
- Reset mid-frame: the frame is aborted at the next edge, the line returns to 0, and no `frame_done` is produced.
- `in_valid` asserted during reset: the word is not accepted.

## Timing
- Let the accept edge end cycle N, with P = 1 if parity is compiled in, else 0.
- Preamble: `data_out` = 1, 0, 1, 1 in cycles N+1 … N+4.
- Data: `in_data[DATA_W-1]` in cycle N+5, through `in_data[0]` in cycle N+4+DATA_W.
- Parity: cycle N+5+DATA_W, if P = 1.
- Gap: cycles N+5+DATA_W+P … N+4+DATA_W+P+GAP_BITS. `frame_done` is high in the last of these cycles.
- `in_ready` is high again in cycle N+5+DATA_W+P+GAP_BITS.
- Minimum accept-to-accept spacing is 5+DATA_W+P+GAP_BITS cycles. With defaults and no parity this is 15.
- `in_valid` held high continuously produces back-to-back frames at exactly that spacing.
- All outputs except `in_ready` are registered. `in_ready` is combinational from `state` and `reset`.

## Configuration
- Macro: `SEQ_FRAME_TX_PARITY_EN`.
- Defined: the PAR state is inserted between DATA and GAP. It drives one bit equal to the XOR of the captured word (even parity), and P = 1.
- Undefined: the PAR state and parity logic are not compiled. DATA goes directly to GAP, and P = 0.

## Test plan
1. Reset held 3 cycles, then released:
   - During reset: `data_out` = 0, `state` = 0, `in_ready` = 0.
   - First cycle after release: `in_ready` = 1.
2. Defaults, no parity, `in_data` = 8'hA5 accepted at cycle N:
   - `data_out` over N+1 … N+14 = 1011 10100101 00.
   - `frame_done` is high only at N+14.
   - `in_ready` is high at N+15.
3. Back-to-back frames, `in_valid` held high with 8'h00 then 8'hFF:
   - Accepts occur exactly 15 cycles apart.
   - Second frame's data bits are all 1.
   - `in_data` changes during the first frame do not corrupt it.
4. Parity macro defined, `in_data` = 8'h07:
   - Parity bit = 1 at N+13.
   - Gap at N+14 … N+15.
   - Next accept possible at N+16.
5. Reset asserted at N+7 (mid-data):
   - At the next edge: `state` = 0, `data_out` = 0, no `frame_done`.
   - A new word is accepted cleanly after release.
6. Loopback into the "1011" sequence detector with payload 8'h00:
   - Detector output pulses once per frame, immediately after the preamble.

Source files
------------

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: preamble 1011, payload MSB first, optional parity, zero gap.
// Optional even-parity bit is compiled in with SEQ_FRAME_TX_PARITY_EN.
module seq_frame_tx #(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              data_out,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        state
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(GAP_BITS + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam logic [2:0] PAR  = 3'd3;
`endif
  localparam logic [2:0] GAP  = 3'd4;

  localparam logic [3:0] PRE_PAT = 4'b1011;

  logic [2:0]        state_q, state_d;
  logic [1:0]        pre_idx_q, pre_idx_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              data_out_q, data_out_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pre_idx_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pre_idx_q    <= pre_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_idx_d = pre_idx_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = PRE;
          pre_idx_d = 2'd0;
          shift_d   = in_data;
`ifdef SEQ_FRAME_TX_PARITY_EN
          parity_d  = ^in_data;
`endif
        end
      end
      PRE: begin
        if (pre_idx_q == 2'd3) begin
          state_d   = DATA;
          bit_cnt_d = CNT_W'(DATA_W);
        end else begin
          pre_idx_d = pre_idx_q + 2'd1;
        end
      end
      DATA: begin
        if (bit_cnt_q == CNT_W'(1)) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
          state_d   = PAR;
`else
          state_d   = GAP;
          gap_cnt_d = GAP_W'(GAP_BITS);
`endif
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      PAR: begin
        state_d   = GAP;
        gap_cnt_d = GAP_W'(GAP_BITS);
      end
`endif
      GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // The MSB leaving now is registered onto the line, so consume it on the same edge
    if (state_d == DATA) begin
      shift_d = shift_q << 1;
    end
  end

  // Line value is decoded from the upcoming state so it lands registered in that state's cycle
  always_comb begin
    data_out_d   = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_d)
      PRE:  data_out_d = PRE_PAT[2'd3 - pre_idx_d];
      DATA: data_out_d = shift_q[DATA_W-1];
`ifdef SEQ_FRAME_TX_PARITY_EN
      PAR:  data_out_d = parity_q;
`endif
      GAP:  frame_done_d = (gap_cnt_d == GAP_W'(1));
      default: data_out_d = 1'b0;
    endcase
  end

  assign state      = state_q;
  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign in_ready   = (state_q == IDLE) && !reset;

endmodule
